// File: rtl/pll_rst_pkg.sv
// Shared types and sizing helpers for the PLL reset sequencer.
package pll_rst_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } seq_state_t;

  localparam int LOCK_CNT_W = 8;

  // Bits needed to hold values 0..value-1 (0 for value <= 1).
  function automatic int clog2(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 32; i++) begin
      if ((longint'(1) << i) < longint'(value)) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level, both flops clear to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  // Next values: shift the async level through two stages.
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Synchroniser register chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: waits for a stable synchronised lock, then releases
// NUM_STAGES resets in order. Loss of lock or a software request restarts it.
// Optional lock-wait timeout flag is built when PLL_RST_SEQ_TIMEOUT_EN is defined.
//
// state     | meaning
// WAIT_LOCK | all resets held, waiting for synchronised lock
// STABLE    | counting consecutive locked cycles
// RELEASE   | releasing one stage every STAGE_GAP cycles
// RUN       | all stages released, seq_done high
module pll_reset_sequencer #(
  parameter int NUM_STAGES     = 4,
  parameter int STABLE_CYCLES  = 1024,
  parameter int STAGE_GAP      = 16,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pll_locked,
  input  logic                  sw_rst_req,
  output logic [NUM_STAGES-1:0] rst_out,
  output logic                  seq_done,
  output logic [7:0]            lock_loss_cnt,
  output logic                  lock_timeout
);
  import pll_rst_pkg::*;

  localparam int CNT_MAX = (STABLE_CYCLES > STAGE_GAP) ? STABLE_CYCLES : STAGE_GAP;
  localparam int CNT_W   = (clog2(CNT_MAX) < 1) ? 1 : clog2(CNT_MAX);
  localparam int STG_W   = (clog2(NUM_STAGES) < 1) ? 1 : clog2(NUM_STAGES);
  localparam logic [CNT_W-1:0]      STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]      GAP_LAST    = CNT_W'(STAGE_GAP - 1);
  localparam logic [STG_W-1:0]      STG_LAST    = STG_W'(NUM_STAGES - 1);
  localparam logic [NUM_STAGES-1:0] ALL_RST     = '1;

  if (NUM_STAGES < 1 || NUM_STAGES > 8 || STABLE_CYCLES < 1 || STAGE_GAP < 1 ||
      TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("pll_reset_sequencer: parameter out of range");
  end

  seq_state_t               state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [STG_W-1:0]         stg_q, stg_d;
  logic [NUM_STAGES-1:0]    rst_out_q, rst_out_d;
  logic                     seq_done_q, seq_done_d;
  logic [LOCK_CNT_W-1:0]    lock_loss_cnt_q, lock_loss_cnt_d;
  logic                     lk_s;
  logic                     lock_lost;

  sync_2ff u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (pll_locked),
    .q   (lk_s)
  );

  // Sequencing FSM: next state, counters and registered outputs.
  // rst_out is shifted left with zero fill so stages always release bit 0 first.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    stg_d           = stg_q;
    rst_out_d       = rst_out_q;
    seq_done_d      = seq_done_q;
    lock_loss_cnt_d = lock_loss_cnt_q;
    lock_lost       = !lk_s && (state_q == RELEASE || state_q == RUN);

    if (lock_lost && lock_loss_cnt_q != '1)
      lock_loss_cnt_d = lock_loss_cnt_q + LOCK_CNT_W'(1);

    if (sw_rst_req || lock_lost) begin
      state_d    = WAIT_LOCK;
      rst_out_d  = ALL_RST;
      seq_done_d = 1'b0;
      cnt_d      = '0;
      stg_d      = '0;
    end else begin
      case (state_q)
        WAIT_LOCK: begin
          rst_out_d  = ALL_RST;
          seq_done_d = 1'b0;
          if (lk_s) begin
            cnt_d   = '0;
            state_d = STABLE;
          end
        end
        STABLE: begin
          if (!lk_s) begin
            state_d = WAIT_LOCK;
          end else if (cnt_q == STABLE_LAST) begin
            cnt_d     = '0;
            stg_d     = '0;
            rst_out_d = ALL_RST << 1;
            state_d   = RELEASE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        RELEASE: begin
          if (stg_q == STG_LAST) begin
            state_d    = RUN;
            seq_done_d = 1'b1;
          end else if (cnt_q == GAP_LAST) begin
            cnt_d     = '0;
            stg_d     = stg_q + STG_W'(1);
            rst_out_d = rst_out_q << 1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        RUN: begin
          seq_done_d = 1'b1;
        end
        default: begin
          state_d   = WAIT_LOCK;
          rst_out_d = ALL_RST;
        end
      endcase
    end
  end

  // Sequencer state and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= WAIT_LOCK;
      cnt_q           <= '0;
      stg_q           <= '0;
      rst_out_q       <= ALL_RST;
      seq_done_q      <= 1'b0;
      lock_loss_cnt_q <= '0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      stg_q           <= stg_d;
      rst_out_q       <= rst_out_d;
      seq_done_q      <= seq_done_d;
      lock_loss_cnt_q <= lock_loss_cnt_d;
    end
  end

`ifdef PLL_RST_SEQ_TIMEOUT_EN
  localparam int WAIT_W = (clog2(TIMEOUT_CYCLES) < 1) ? 1 : clog2(TIMEOUT_CYCLES);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              lock_timeout_q, lock_timeout_d;

  // Lock-wait counter runs only while staying in WAIT_LOCK; the flag is sticky.
  always_comb begin
    wait_cnt_d     = '0;
    lock_timeout_d = lock_timeout_q;
    if (state_q == WAIT_LOCK && state_d == WAIT_LOCK) begin
      if (wait_cnt_q == WAIT_LAST) begin
        wait_cnt_d     = wait_cnt_q;
        lock_timeout_d = 1'b1;
      end else begin
        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
      end
    end
  end

  // Timeout counter and flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q     <= '0;
      lock_timeout_q <= 1'b0;
    end else begin
      wait_cnt_q     <= wait_cnt_d;
      lock_timeout_q <= lock_timeout_d;
    end
  end

  assign lock_timeout = lock_timeout_q;
`else
  assign lock_timeout = 1'b0;
`endif

  assign rst_out       = rst_out_q;
  assign seq_done      = seq_done_q;
  assign lock_loss_cnt = lock_loss_cnt_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench for pll_reset_sequencer. Directed scenarios plus random
// lock/sw_rst_req traffic feed a timeline-level reference model; each predicted
// output change is queued and matched against observed DUT output changes.
module tb_pll_reset_sequencer;

  localparam int N = 4;
  localparam int S = 8;
  localparam int G = 4;
  localparam int T = 32;

`ifdef PLL_RST_SEQ_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         pll_locked = 1'b0;
  logic         sw_rst_req = 1'b0;
  logic [N-1:0] rst_out;
  logic         seq_done;
  logic [7:0]   lock_loss_cnt;
  logic         lock_timeout;

  pll_reset_sequencer #(
    .NUM_STAGES     (N),
    .STABLE_CYCLES  (S),
    .STAGE_GAP      (G),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pll_locked    (pll_locked),
    .sw_rst_req    (sw_rst_req),
    .rst_out       (rst_out),
    .seq_done      (seq_done),
    .lock_loss_cnt (lock_loss_cnt),
    .lock_timeout  (lock_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           cyc;
    logic [N-1:0] ro;
    logic         done;
    logic [7:0]   lc;
    logic         to;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: a sequence is "armed" at the edge where synchronised lock
  // is seen while idle. Relative to that edge (distance d), stage k releases at
  // d = S + k*G, seq_done at d = S + (N-1)*G + 1; lock loss only counts at d > S.
  bit   m_s1 = 0, m_s2 = 0;
  bit   m_active = 0;
  int   m_armed = 0;
  int   m_wait_run = 0;
  logic [7:0] m_lc = 0;
  bit   m_to = 0;
  exp_t m_prev = '{0, '1, 1'b0, 8'd0, 1'b0};

  function automatic void model_edge(input bit r, input bit l, input bit s);
    int   n, d, released;
    bit   lk;
    exp_t e;
    n  = cyc + 1;
    lk = m_s2;
    if (r) begin
      m_s1 = 0; m_s2 = 0; m_active = 0; m_wait_run = 0; m_lc = 0; m_to = 0;
    end else begin
      m_s2 = m_s1;
      m_s1 = l;
      if (m_active) begin
        d = n - m_armed;
        if (s || !lk) begin
          if (!lk && d > S && m_lc != 8'd255) m_lc = m_lc + 8'd1;
          m_active   = 0;
          m_wait_run = 0;
        end
      end else if (lk && !s) begin
        m_active   = 1;
        m_armed    = n;
        m_wait_run = 0;
      end else begin
        m_wait_run++;
        if (TO_EN && m_wait_run >= T) m_to = 1;
      end
    end
    released = 0;
    e.done   = 1'b0;
    if (m_active) begin
      d = n - m_armed;
      if (d >= S) released = ((d - S) / G + 1 > N) ? N : (d - S) / G + 1;
      e.done = (d >= S + (N - 1) * G + 1);
    end
    e.ro = '1;
    for (int k = 0; k < N; k++) if (k < released) e.ro[k] = 1'b0;
    e.cyc = n;
    e.lc  = m_lc;
    e.to  = m_to;
    if (e.ro != m_prev.ro || e.done != m_prev.done || e.lc != m_prev.lc || e.to != m_prev.to)
      exp_q.push_back(e);
    m_prev = e;
  endfunction

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endfunction

  task automatic step(input bit r, input bit l, input bit s);
    @(negedge clk);
    rst        = r;
    pll_locked = l;
    sw_rst_req = s;
    model_edge(r, l, s);
  endtask

  // Monitor: pops one expectation per observed DUT output change.
  initial begin : monitor
    logic [N+9:0] cur, prev;
    exp_t e;
    @(negedge clk);
    cur = {rst_out, seq_done, lock_loss_cnt, lock_timeout};
    chk("reset_state", 32'(cur), 32'({4'hF, 1'b0, 8'd0, 1'b0}));
    prev = cur;
    forever begin
      @(negedge clk);
      cur = {rst_out, seq_done, lock_loss_cnt, lock_timeout};
      if (cur !== prev) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_change: cycle %0d rst_out=%h seq_done=%b lock_loss_cnt=%0d lock_timeout=%b, required no change",
                   cyc, rst_out, seq_done, lock_loss_cnt, lock_timeout);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc || cur !== {e.ro, e.done, e.lc, e.to}) begin
            n_fail++;
            $display("FAIL output_event: got cycle %0d rst_out=%h seq_done=%b lock_loss_cnt=%0d lock_timeout=%b, required cycle %0d rst_out=%h seq_done=%b lock_loss_cnt=%0d lock_timeout=%b",
                     cyc, rst_out, seq_done, lock_loss_cnt, lock_timeout,
                     e.cyc, e.ro, e.done, e.lc, e.to);
          end
        end
        prev = cur;
      end
    end
  end

  initial begin : stimulus
    int  len;
    bit  lv;
    repeat (3) step(1, 0, 0);
    // Clean start: lock arrives on the fifth cycle after reset drops.
    repeat (4) step(0, 0, 0);
    repeat (40) step(0, 1, 0);
    // Lock loss in RUN for a single cycle, then re-sequence.
    step(0, 0, 0);
    repeat (40) step(0, 1, 0);
    // Lock loss, then a 2-cycle glitch after 5 locked cycles.
    repeat (3) step(0, 0, 0);
    repeat (5) step(0, 1, 0);
    repeat (2) step(0, 0, 0);
    repeat (40) step(0, 1, 0);
    // Software request while stage 2 is the most recent release.
    step(0, 1, 1);
    repeat (S + 2 * G + 1) step(0, 1, 0);
    step(0, 1, 1);
    repeat (40) step(0, 1, 0);
    // Long lock absence (timeout window), then lock returns.
    repeat (40) step(0, 0, 0);
    repeat (40) step(0, 1, 0);
    chk("timeout_sticky", 32'(lock_timeout), 32'(TO_EN));
    // Random lock and software-request traffic.
    for (int i = 0; i < 40; i++) begin
      len = $urandom_range(1, 25);
      lv  = ($urandom_range(0, 3) != 0);
      for (int j = 0; j < len; j++) step(0, lv, $urandom_range(0, 31) == 0);
    end
    // Saturation: 260 counted lock losses.
    for (int i = 0; i < 260; i++) begin
      len = $urandom_range(10, 20);
      repeat (len) step(0, 1, 0);
      step(0, 0, 0);
    end
    step(0, 1, 0);
    chk("lock_loss_saturated", 32'(lock_loss_cnt), 32'd255);
    repeat (30) step(0, 1, 0);
    // Reset mid-run returns everything to reset values.
    repeat (2) step(1, 1, 0);
    chk("rst_rst_out", 32'(rst_out), 32'hF);
    chk("rst_seq_done", 32'(seq_done), 32'd0);
    chk("rst_lock_loss_cnt", 32'(lock_loss_cnt), 32'd0);
    chk("rst_lock_timeout", 32'(lock_timeout), 32'd0);
    repeat (30) step(0, 1, 0);
    repeat (4) step(1, 0, 0);
    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
